seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 105 ++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider producing one quotient bit per RUN cycle.
// A zero divisor skips RUN and reports all-ones quotient with the dividend as remainder.
module seq_divider #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);
    localparam int CW = $clog2(n + 1);
    localparam logic [CW-1:0] N_STEPS = CW'(n);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [n:0]    prem_q, prem_d;
    logic [n-1:0]  qreg_q, qreg_d;
    logic [n-1:0]  dvs_q, dvs_d;
    logic [n-1:0]  quot_q, quot_d;
    logic [n-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n:0]    sh;
    logic [n+1:0]  sum;
    logic          no_borrow;
    logic          unused_prem_msb;

    // Top bit of the partial remainder is always 0 after a restoring step.
    assign unused_prem_msb = prem_q[n];

    // Trial subtraction as add with inverted divisor and carry-in 1; carry-out means no borrow.
    assign sh        = {prem_q[n-1:0], qreg_q[n-1]};
    assign sum       = {1'b0, sh} + {1'b0, ~{1'b0, dvs_q}} + (n + 2)'(1);
    assign no_borrow = sum[n+1];

    always_comb begin
        state_d = state_q;
        prem_d  = prem_q;
        qreg_d  = qreg_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                dvs_d   = divisor;
                prem_d  = '0;
                qreg_d  = dividend;
                cnt_d   = N_STEPS;
                state_d = (divisor == '0) ? DONE : RUN;
                dbz_d   = (divisor == '0);
                quot_d  = (divisor == '0) ? '1 : quot_q;
                rem_d   = (divisor == '0) ? dividend : rem_q;
            end
            RUN: begin
                prem_d = no_borrow ? sum[n:0] : sh;
                qreg_d = {qreg_q[n-2:0], no_borrow};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quot_d  = {qreg_q[n-2:0], no_borrow};
                    rem_d   = no_borrow ? sum[n-1:0] : sh[n-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            prem_q  <= '0;
            qreg_q  <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prem_q  <= prem_d;
            qreg_q  <= qreg_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
endmodule
